// File: rtl/branch_unit.sv
// ============================================================================
// Module   : branch_unit
// Purpose  : ID-stage BEQ/BNE/J resolution with hazard stall, PC redirect,
//            IF/ID flush and saturating branch statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_unit #(
    parameter int PC_SIZE    = 32,
    parameter int REG_ADDR   = 5,
    parameter int CNT_WIDTH  = 16,
    parameter int DELAY_SLOT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 id_valid,
    input  logic                 id_kill,
    input  logic                 id_is_beq,
    input  logic                 id_is_bne,
    input  logic                 id_is_jump,
    input  logic                 id_use_rt,
    input  logic [REG_ADDR-1:0]  id_rs,
    input  logic [REG_ADDR-1:0]  id_rt,
    input  logic [PC_SIZE-1:0]   id_pc_plus4,
    input  logic [PC_SIZE-1:0]   id_imm,
    input  logic                 cmp_eq,
    input  logic                 ex_reg_write,
    input  logic                 ex_mem_read,
    input  logic [REG_ADDR-1:0]  ex_rd,
    input  logic                 mem_mem_read,
    input  logic [REG_ADDR-1:0]  mem_rd,
    input  logic                 clr_stats,
    output logic                 stall,
    output logic                 pc_redirect,
    output logic [PC_SIZE-1:0]   branch_target,
    output logic                 flush_ifid,
    output logic [CNT_WIDTH-1:0] br_count,
    output logic [CNT_WIDTH-1:0] taken_count,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam logic [0:0]           c_st_idle  = 1'b0;
    localparam logic [0:0]           c_st_stall = 1'b1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    logic [0:0]           r_state;
    logic [0:0]           w_state_nxt;
    logic [1:0]           r_cnt;
    logic [1:0]           w_cnt_nxt;
    logic [1:0]           w_depth;
    logic                 w_is_br;
    logic                 w_is_j;
    logic                 w_ex_match;
    logic                 w_mem_match;
    logic                 w_stall;
    logic                 w_resolve;
    logic                 w_taken;
    logic [CNT_WIDTH-1:0] r_br_count;
    logic [CNT_WIDTH-1:0] r_taken_count;
    logic [CNT_WIDTH-1:0] r_stall_count;

    assign w_is_br = id_valid & ~id_kill & (id_is_beq | id_is_bne);
    assign w_is_j  = id_valid & ~id_kill & id_is_jump;

    // Register 0 is hardwired, so a zero destination never creates a hazard
    assign w_ex_match  = (ex_rd != '0) &&
                         ((ex_rd == id_rs) || (id_use_rt && (ex_rd == id_rt)));
    assign w_mem_match = (mem_rd != '0) &&
                         ((mem_rd == id_rs) || (id_use_rt && (mem_rd == id_rt)));

    always_comb begin
        w_depth = 2'd0;
        if (ex_reg_write && ex_mem_read && w_ex_match) begin
            w_depth = 2'd2;
        end else if ((ex_reg_write && w_ex_match) || (mem_mem_read && w_mem_match)) begin
            w_depth = 2'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stall     = 1'b0;
        w_resolve   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_is_br && (w_depth != 2'd0)) begin
                    w_stall     = 1'b1;
                    w_state_nxt = c_st_stall;
                    w_cnt_nxt   = w_depth - 2'd1;
                end else if (w_is_br || w_is_j) begin
                    w_resolve = 1'b1;
                end
            end
            default: begin
                if (!id_valid || id_kill) begin
                    w_state_nxt = c_st_idle;
                    w_cnt_nxt   = 2'd0;
                end else if (r_cnt != 2'd0) begin
                    w_stall   = 1'b1;
                    w_cnt_nxt = r_cnt - 2'd1;
                end else begin
                    // Operands are forwardable now; the held branch resolves
                    w_resolve   = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
        endcase
    end

    assign w_taken = w_is_j | (id_is_beq & cmp_eq) | (id_is_bne & ~cmp_eq);

    // Outputs are gated by reset so an asserted rst_n silences the unit at once
    assign stall         = rst_n & w_stall;
    assign pc_redirect   = rst_n & w_resolve & w_taken;
    assign flush_ifid    = rst_n & w_resolve & w_taken & (DELAY_SLOT == 0);
    assign branch_target = id_pc_plus4 + {id_imm[PC_SIZE-3:0], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_br_count    <= '0;
            r_taken_count <= '0;
            r_stall_count <= '0;
        end else if (clr_stats) begin
            r_br_count    <= '0;
            r_taken_count <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_resolve && (r_br_count != c_cnt_max)) begin
                r_br_count <= r_br_count + c_cnt_one;
            end
            if (w_resolve && w_taken && (r_taken_count != c_cnt_max)) begin
                r_taken_count <= r_taken_count + c_cnt_one;
            end
            if (w_stall && (r_stall_count != c_cnt_max)) begin
                r_stall_count <= r_stall_count + c_cnt_one;
            end
        end
    end

    assign br_count    = r_br_count;
    assign taken_count = r_taken_count;
    assign stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_branch_unit.sv
// ============================================================================
// Module   : tb_branch_unit
// Purpose  : Directed self-checking bench for branch_unit (default build and a
//            DELAY_SLOT=1 / CNT_WIDTH=2 build driven by the same stimulus).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_unit;

    logic        clk;
    logic        rst_n;
    logic        id_valid, id_kill, id_is_beq, id_is_bne, id_is_jump, id_use_rt;
    logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
    logic [31:0] id_pc_plus4, id_imm;
    logic        cmp_eq, ex_reg_write, ex_mem_read, mem_mem_read, clr_stats;

    logic        stall, pc_redirect, flush_ifid;
    logic [31:0] branch_target;
    logic [15:0] br_count, taken_count, stall_count;

    logic        s_stall, s_redirect, s_flush;
    logic [31:0] s_target;
    logic [1:0]  s_br, s_taken, s_stallc;

    int n_checks;
    int n_errors;

    branch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_kill(id_kill),
        .id_is_beq(id_is_beq), .id_is_bne(id_is_bne), .id_is_jump(id_is_jump),
        .id_use_rt(id_use_rt), .id_rs(id_rs), .id_rt(id_rt),
        .id_pc_plus4(id_pc_plus4), .id_imm(id_imm), .cmp_eq(cmp_eq),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .clr_stats(clr_stats),
        .stall(stall), .pc_redirect(pc_redirect), .branch_target(branch_target),
        .flush_ifid(flush_ifid), .br_count(br_count), .taken_count(taken_count),
        .stall_count(stall_count)
    );

    branch_unit #(.PC_SIZE(32), .REG_ADDR(5), .CNT_WIDTH(2), .DELAY_SLOT(1)) u_dut_ds (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_kill(id_kill),
        .id_is_beq(id_is_beq), .id_is_bne(id_is_bne), .id_is_jump(id_is_jump),
        .id_use_rt(id_use_rt), .id_rs(id_rs), .id_rt(id_rt),
        .id_pc_plus4(id_pc_plus4), .id_imm(id_imm), .cmp_eq(cmp_eq),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .mem_mem_read(mem_mem_read), .mem_rd(mem_rd), .clr_stats(clr_stats),
        .stall(s_stall), .pc_redirect(s_redirect), .branch_target(s_target),
        .flush_ifid(s_flush), .br_count(s_br), .taken_count(s_taken),
        .stall_count(s_stallc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_kill = 0; id_is_beq = 0; id_is_bne = 0; id_is_jump = 0;
        id_use_rt = 0; id_rs = 0; id_rt = 0; id_pc_plus4 = 0; id_imm = 0;
        cmp_eq = 0; ex_reg_write = 0; ex_mem_read = 0; ex_rd = 0;
        mem_mem_read = 0; mem_rd = 0; clr_stats = 0;
    endtask

    // Advance one clock edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctl(input string tag, input logic st, input logic rd, input logic fl);
        check({tag, "_stall"}, 64'(stall), 64'(st));
        check({tag, "_redir"}, 64'(pc_redirect), 64'(rd));
        check({tag, "_flush"}, 64'(flush_ifid), 64'(fl));
    endtask

    task automatic check_cnt(input string tag, input int br, input int tk, input int sc);
        check({tag, "_br"},    64'(br_count),    64'(br));
        check({tag, "_taken"}, 64'(taken_count), 64'(tk));
        check({tag, "_stcnt"}, 64'(stall_count), 64'(sc));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_inputs();
        rst_n = 0;
        #12;
        check_ctl("reset", 0, 0, 0);
        check_cnt("reset", 0, 0, 0);
        check("reset_ds_br", 64'(s_br), 64'd0);
        rst_n = 1;
        tick();

        // BEQ taken, no hazard: immediate redirect
        id_valid = 1; id_is_beq = 1; id_rs = 1; id_pc_plus4 = 32'h100; id_imm = 32'h3; cmp_eq = 1;
        #1;
        check_ctl("beq", 0, 1, 1);
        check("beq_target", 64'(branch_target), 64'h10C);
        check("beq_ds_flush", 64'(s_flush), 64'd0);
        check("beq_ds_redir", 64'(s_redirect), 64'd1);
        tick();
        check_cnt("beq", 1, 1, 0);

        // BNE with ALU producer in EX on rs: one stall cycle
        clear_inputs();
        id_valid = 1; id_is_bne = 1; id_rs = 5; ex_reg_write = 1; ex_rd = 5; cmp_eq = 0;
        #1;
        check_ctl("bne_s0", 1, 0, 0);
        tick();
        check_ctl("bne_res", 0, 1, 1);
        tick();
        check_cnt("bne", 2, 2, 1);

        // BEQ with load in EX on rt: two stall cycles, not taken
        clear_inputs();
        id_valid = 1; id_is_beq = 1; id_use_rt = 1; id_rs = 3; id_rt = 7;
        ex_reg_write = 1; ex_mem_read = 1; ex_rd = 7; cmp_eq = 0;
        #1;
        check_ctl("ld_s0", 1, 0, 0);
        tick();
        check_ctl("ld_s1", 1, 0, 0);
        tick();
        check_ctl("ld_res", 0, 0, 0);
        tick();
        check_cnt("ld", 3, 2, 3);
        check("ld_ds_br_sat", 64'(s_br), 64'd3);
        check("ld_ds_stcnt", 64'(s_stallc), 64'd3);

        // Same load but rt not compared: no stall
        id_use_rt = 0;
        #1;
        check_ctl("ld_nort", 0, 0, 0);
        tick();
        check_cnt("ld_nort", 4, 2, 3);

        // Zero register in EX never hazards
        clear_inputs();
        id_valid = 1; id_is_beq = 1; id_rs = 0; ex_reg_write = 1; ex_rd = 0; cmp_eq = 1;
        #1;
        check_ctl("r0", 0, 1, 1);
        tick();

        // Jump ignores an EX load hazard; negative offset
        clear_inputs();
        id_valid = 1; id_is_jump = 1; id_rs = 5; ex_reg_write = 1; ex_mem_read = 1; ex_rd = 5;
        id_pc_plus4 = 32'h200; id_imm = 32'hFFFF_FFFF;
        #1;
        check_ctl("jmp", 0, 1, 1);
        check("jmp_target", 64'(branch_target), 64'h1FC);
        tick();
        check_cnt("jmp", 6, 4, 3);

        // Load in MEM on rs: one stall cycle
        clear_inputs();
        id_valid = 1; id_is_beq = 1; id_rs = 9; mem_mem_read = 1; mem_rd = 9; cmp_eq = 1;
        #1;
        check_ctl("mem_s0", 1, 0, 0);
        tick();
        check_ctl("mem_res", 0, 1, 1);
        tick();
        check_cnt("mem", 7, 5, 4);

        // Kill during the second stall cycle of a load hazard
        clear_inputs();
        id_valid = 1; id_is_beq = 1; id_use_rt = 1; id_rt = 7;
        ex_reg_write = 1; ex_mem_read = 1; ex_rd = 7; cmp_eq = 1;
        #1;
        check_ctl("kill_s0", 1, 0, 0);
        tick();
        id_kill = 1;
        #1;
        check_ctl("kill", 0, 0, 0);
        tick();
        id_kill = 0;
        check_cnt("kill", 7, 5, 5);
        // Back in IDLE the same hazard must start a fresh stall
        #1;
        check_ctl("kill_idle", 1, 0, 0);

        // Asynchronous reset in the middle of a stall
        #2;
        rst_n = 0;
        #1;
        check_ctl("areset", 0, 0, 0);
        check_cnt("areset", 0, 0, 0);
        clear_inputs();
        tick();
        rst_n = 1;
        tick();

        // clr_stats wins over a coincident resolve
        id_valid = 1; id_is_jump = 1;
        tick();
        check("pre_clr_br", 64'(br_count), 64'd1);
        clr_stats = 1;
        #1;
        check("clr_redir", 64'(pc_redirect), 64'd1);
        tick();
        check_cnt("clr", 0, 0, 0);
        check("clr_ds_taken", 64'(s_taken), 64'd0);
        clr_stats = 0;

        // Five taken jumps: 2-bit counters saturate at 3, delay slot never flushes
        for (int i = 0; i < 5; i++) begin
            #1;
            check("sat_ds_flush", 64'(s_flush), 64'd0);
            tick();
        end
        check("sat_ds_br", 64'(s_br), 64'd3);
        check("sat_ds_taken", 64'(s_taken), 64'd3);
        check("sat_br", 64'(br_count), 64'd5);
        check("sat_taken", 64'(taken_count), 64'd5);

        clear_inputs();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/branch_unit.md
Name: branch_unit

Overview:
- ID-stage branch/jump control; sits directly downstream of the ID equality comparer and consumes its result.
- Resolves BEQ/BNE/J in ID and computes the PC-relative target.
- Stalls the front end when a branch operand is not yet forwardable.
- Drives PC redirect and the IF/ID flush, and keeps saturating branch statistics.

Parameters:
PC_SIZE, 32, width of PC, offset and target
REG_ADDR, 5, register specifier width
CNT_WIDTH, 16, width of each statistics counter
DELAY_SLOT, 0, 0 = flush IF/ID on redirect; 1 = architectural delay slot, never flush

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
id_valid  in  1  ID holds a valid instruction
id_kill  in  1  squash the ID instruction (exception or upstream flush)
id_is_beq  in  1  decoded BEQ
id_is_bne  in  1  decoded BNE
id_is_jump  in  1  decoded J (PC-relative, no operands)
id_use_rt  in  1  branch compares rs with rt (0 = rs only)
id_rs, id_rt  in  REG_ADDR  source specifiers
id_pc_plus4  in  PC_SIZE  PC+4 of the ID instruction
id_imm  in  PC_SIZE  sign-extended word offset
cmp_eq  in  1  equality result from the ID comparer (forwarded operands)
ex_reg_write, ex_mem_read  in  1  EX-stage producer flags
ex_rd  in  REG_ADDR  EX destination
mem_mem_read  in  1  MEM-stage load flag
mem_rd  in  REG_ADDR  MEM destination
clr_stats  in  1  synchronous statistics clear
stall  out  1  freeze PC and IF/ID; ID/EX receives a bubble
pc_redirect  out  1  PC loads branch_target this cycle
branch_target  out  PC_SIZE  id_pc_plus4 + (id_imm<<2), mod 2^PC_SIZE
flush_ifid  out  1  squash the instruction in IF/ID
br_count, taken_count, stall_count  out  CNT_WIDTH  statistics

Behaviour:
- is_br = id_valid & ~id_kill & (id_is_beq | id_is_bne).
- is_j = id_valid & ~id_kill & id_is_jump.
- A match is a nonzero register specifier equal to id_rs, or equal to id_rt when id_use_rt=1.
- Hazard depth N:
  - 2 if ex_reg_write & ex_mem_read & EX match.
  - 1 if ex_reg_write & ~ex_mem_read & EX match.
  - 1 if mem_mem_read & MEM match.
  - Otherwise 0. Take the maximum of all that apply.
  - Jumps never hazard.
- States and a 2-bit counter cnt; reset: IDLE, cnt=0, all counters 0.
- IDLE:
  - If is_br & N>0: stall=1, then next state STALL with cnt<=N-1.
  - Else resolve this cycle when is_br or is_j.
- STALL:
  - If cnt!=0: stall=1, cnt<=cnt-1.
  - If cnt==0: no hazard check; resolve this cycle, then next state IDLE.
  - If id_kill=1 or id_valid=0 in STALL: stall=0, no resolve, next state IDLE, cnt<=0.
- Upstream holds all ID inputs stable while stall=1.
- Resolve cycle:
  - taken = is_j | (id_is_beq & cmp_eq) | (id_is_bne & ~cmp_eq).
  - pc_redirect = taken.
  - flush_ifid = taken & (DELAY_SLOT==0).
- stall, pc_redirect and flush_ifid are combinational from state and inputs; they are never asserted together.
- branch_target is always driven combinationally; it is meaningful only when pc_redirect=1.
- Statistics (clock edge):
  - br_count +1 per resolve; taken_count +1 per taken resolve; stall_count +1 per cycle with stall=1.
  - Each counter saturates at all-ones.
  - clr_stats zeroes all three and has priority over increments in the same cycle.
- Reset asserted mid-stall returns to IDLE immediately (async) with all outputs deasserted.

Test Plan:
- BEQ, no hazard, cmp_eq=1, id_pc_plus4=0x100, id_imm=0x3 -> same cycle pc_redirect=1, branch_target=0x10C, flush_ifid=1, stall=0; br_count=1, taken_count=1.
- BNE with ALU producer in EX writing rs=5 -> stall=1 for exactly 1 cycle, resolves next cycle; stall_count=1.
- BEQ with load in EX writing rt=7, id_use_rt=1 -> stall=1 for 2 cycles, resolves on the 3rd; with id_use_rt=0 -> no stall.
- ex_rd=0 with ex_reg_write=1 and rs=0 -> no stall; J with EX hazard present -> immediate redirect, stall=0.
- id_kill asserted during the 2nd stall cycle -> stall=0 that cycle, no redirect, state IDLE, br_count unchanged; async rst_n mid-stall -> all outputs 0.
- DELAY_SLOT=1, taken branch -> flush_ifid=0. CNT_WIDTH=2 with 5 taken branches -> counters hold 3. clr_stats coincident with a resolve -> counters 0.
